cond_branch_sequencer: RTL and testbench

//  Multi-cycle conditional-branch sequencer in the control unit; successor to the single-cycle CBZ/CBNZ decode path.

---
 rtl/cond_branch_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_cond_branch_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cond_branch_sequencer.sv
// Multi-cycle CBZ/CBNZ/B.cond sequencer: IDLE -> TEST -> UPDATE.
// Latches the branch, resolves it from ALU zero / stored flags, steers the PC and counts outcomes.
module cond_branch_sequencer #(
    parameter int DATA_WIDTH  = 64,
    parameter int COUNT_WIDTH = 16,
    parameter bit W_FORM_EN   = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [31:0]            instruction,
    input  logic [4:0]             status,
    input  logic                   clear_counts,
    output logic [32:0]            controlword,
    output logic [DATA_WIDTH-1:0]  constant,
    output logic                   busy,
    output logic                   done,
    output logic                   taken,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] taken_count,
    output logic [COUNT_WIDTH-1:0] not_taken_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        TEST   = 2'b01,
        UPDATE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        K_CBZ   = 2'b00,
        K_CBNZ  = 2'b01,
        K_BCOND = 2'b10
    } kind_t;

    typedef struct packed {
        logic       alu_en;
        logic       alu_b_sel;
        logic [4:0] alu_fs;
        logic       rfb_en;
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] da;
        logic       rf_w;
        logic       ram_en;
        logic       ram_w;
        logic       pc_en;
        logic [1:0] pc_fs;
        logic       pc_in_sel;
        logic       status_load;
        logic [1:0] next_state;
    } ctrl_t;

    state_t                  state, state_next;
    kind_t                   kind_r;
    logic [23:0]             instr_r;
    logic                    w_form_r;
    logic                    taken_r;
    logic                    illegal_r;
    ctrl_t                   cw;
    logic                    is_cbz, is_cbnz, is_bcond, is_legal, accept;
    logic                    cb_taken, cond_base, cond_taken;
    logic [DATA_WIDTH-1:0]   imm_ext;

    assign is_cbz   = (instruction[30:24] == 7'b0110100);
    assign is_cbnz  = (instruction[30:24] == 7'b0110101);
    assign is_bcond = (instruction[31:24] == 8'b01010100) && !instruction[4];
    assign is_legal = is_cbz || is_cbnz || is_bcond;
    assign accept   = (state == IDLE) && start;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start && is_legal) state_next = TEST;
            TEST:    state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // B.cond: conditions come in pairs, odd encodings invert the even one (AL/NV excepted).
    always_comb begin
        cond_base = 1'b1;
        unique case (instr_r[3:1])
            3'd0: cond_base = status[0];
            3'd1: cond_base = status[2];
            3'd2: cond_base = status[1];
            3'd3: cond_base = status[3];
            3'd4: cond_base = status[2] && !status[0];
            3'd5: cond_base = (status[1] == status[3]);
            3'd6: cond_base = (status[1] == status[3]) && !status[0];
            3'd7: cond_base = 1'b1;
            default: cond_base = 1'b1;
        endcase
    end

    assign cond_taken = cond_base ^ (instr_r[0] && (instr_r[3:1] != 3'd7));
    assign cb_taken   = status[4] ^ (kind_r == K_CBNZ);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_r   <= '0;
            kind_r    <= K_CBZ;
            w_form_r  <= 1'b0;
            taken_r   <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= accept && !is_legal;
            if (accept && is_legal) begin
                instr_r  <= instruction[23:0];
                kind_r   <= is_bcond ? K_BCOND : (is_cbnz ? K_CBNZ : K_CBZ);
                w_form_r <= W_FORM_EN && !instruction[31] && !is_bcond;
            end
            if (state == TEST)
                taken_r <= (kind_r == K_BCOND) ? cond_taken : cb_taken;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            taken_count     <= '0;
            not_taken_count <= '0;
        end else if (clear_counts) begin
            taken_count     <= '0;
            not_taken_count <= '0;
        end else if (state == UPDATE) begin
            if (taken_r && (taken_count != '1))
                taken_count <= taken_count + COUNT_WIDTH'(1);
            if (!taken_r && (not_taken_count != '1))
                not_taken_count <= not_taken_count + COUNT_WIDTH'(1);
        end
    end

    assign imm_ext = {{(DATA_WIDTH-19){instr_r[23]}}, instr_r[23:5]};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        cw       = '0;
        constant = '0;
        unique case (state)
            TEST: begin
                cw.next_state = UPDATE;
                constant      = imm_ext;
                if (kind_r != K_BCOND) begin
                    cw.sa = instr_r[4:0];
                    cw.sb = 5'd31;
                    if (w_form_r) begin
                        cw.alu_b_sel    = 1'b1;
                        cw.alu_fs       = 5'b00000;
                        constant        = '0;
                        constant[31:0]  = 32'hFFFF_FFFF;
                    end else begin
                        cw.alu_fs = 5'b00100;
                    end
                end
            end
            UPDATE: begin
                cw.next_state = IDLE;
                cw.pc_en      = 1'b1;
                cw.pc_fs      = taken_r ? 2'b11 : 2'b01;
                cw.pc_in_sel  = taken_r;
                constant      = imm_ext;
            end
            default: begin
                cw       = '0;
                constant = '0;
            end
        endcase
    end

    assign controlword = cw;
    assign busy        = (state != IDLE);
    assign done        = (state == UPDATE);
    assign taken       = done && taken_r;
    assign illegal     = illegal_r;

endmodule

// File: tb/tb_cond_branch_sequencer.sv
// Randomized self-checking bench for cond_branch_sequencer against a behavioural branch model.
// Counters are narrowed so saturation is reachable in a short run.
module tb_cond_branch_sequencer;

    localparam int DW   = 64;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          clear_counts = 1'b0;
    logic [31:0]   instruction = '0;
    logic [4:0]    status = '0;
    logic [32:0]   controlword;
    logic [DW-1:0] constant;
    logic          busy, done, taken, illegal;
    logic [CW-1:0] taken_count, not_taken_count;

    int checks = 0;
    int errors = 0;
    int model_taken = 0;
    int model_not_taken = 0;

    cond_branch_sequencer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .W_FORM_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .start(start), .instruction(instruction),
        .status(status), .clear_counts(clear_counts), .controlword(controlword),
        .constant(constant), .busy(busy), .done(done), .taken(taken), .illegal(illegal),
        .taken_count(taken_count), .not_taken_count(not_taken_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // 0 CBZ, 1 CBNZ, 2 B.cond, 3 not a branch
    function automatic int kind_of(input logic [31:0] i);
        if (i[30:24] == 7'h34) return 0;
        if (i[30:24] == 7'h35) return 1;
        if (i[31:24] == 8'h54 && !i[4]) return 2;
        return 3;
    endfunction

    // flags = {V, C, N, Z}
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] flags);
        bit z = flags[0], n = flags[1], cy = flags[2], v = flags[3];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [63:0] sext_imm19(input logic [31:0] i);
        longint v = longint'(i[23:5]);
        if (v >= 262144) v = v - 524288;
        return 64'(v);
    endfunction

    function automatic logic [32:0] exp_test_cw(input logic [31:0] i);
        logic [32:0] cw = '0;
        int k = kind_of(i);
        cw[1:0] = 2'b10;
        if (k < 2) begin
            cw[24:20] = i[4:0];
            cw[19:15] = 5'd31;
            if (!i[31]) begin
                cw[31]    = 1'b1;
                cw[30:26] = 5'b00000;
            end else begin
                cw[30:26] = 5'b00100;
            end
        end
        return cw;
    endfunction

    function automatic logic [32:0] exp_update_cw(input bit t);
        logic [32:0] cw = '0;
        cw[6]   = 1'b1;
        cw[5:4] = t ? 2'b11 : 2'b01;
        cw[3]   = t;
        return cw;
    endfunction

    // Called one step after a rising edge with the DUT idle; returns one step after it is idle again.
    task automatic run_branch(input logic [31:0] instr, input logic [4:0] st, input bit clr);
        int k = kind_of(instr);
        bit exp_t;
        instruction = instr;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'($urandom_range(0, 1));
        instruction = $urandom;
        status = st;
        check("test_busy", 64'(busy), 64'd1);
        check("test_done", 64'(done), 64'd0);
        check("test_cw", 64'(controlword), 64'(exp_test_cw(instr)));
        if (k < 2 && !instr[31]) check("test_wconst", constant, 64'h0000_0000_FFFF_FFFF);
        exp_t = (k < 2) ? (st[4] ^ (k == 1)) : cond_holds(instr[3:0], st[3:0]);
        @(posedge clock); #1;
        start = 1'b0;
        status = 5'($urandom);
        clear_counts = clr;
        check("upd_done", 64'(done), 64'd1);
        check("upd_taken", 64'(taken), 64'(exp_t));
        check("upd_cw", 64'(controlword), 64'(exp_update_cw(exp_t)));
        check("upd_illegal", 64'(illegal), 64'd0);
        if (exp_t) check("upd_const", constant, sext_imm19(instr));
        if (clr) begin
            model_taken = 0;
            model_not_taken = 0;
        end else if (exp_t) begin
            if (model_taken < CMAX) model_taken++;
        end else begin
            if (model_not_taken < CMAX) model_not_taken++;
        end
        @(posedge clock); #1;
        clear_counts = 1'b0;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_cw", 64'(controlword), 64'd0);
        check("taken_count", 64'(taken_count), 64'(model_taken));
        check("not_taken_count", 64'(not_taken_count), 64'(model_not_taken));
    endtask

    task automatic run_illegal(input logic [31:0] instr);
        instruction = instr;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("ill_pulse", 64'(illegal), 64'd1);
        check("ill_busy", 64'(busy), 64'd0);
        check("ill_cw", 64'(controlword), 64'd0);
        @(posedge clock); #1;
        check("ill_clear", 64'(illegal), 64'd0);
        check("ill_idle", 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] rand_branch();
        logic [31:0] i = $urandom;
        case ($urandom_range(0, 2))
            0: i[30:24] = 7'h34;
            1: i[30:24] = 7'h35;
            default: begin
                i[31:24] = 8'h54;
                i[4] = 1'b0;
            end
        endcase
        return i;
    endfunction

    initial begin
        logic [31:0] ri;
        #12;
        check("rst_cw", 64'(controlword), 64'd0);
        check("rst_const", constant, 64'd0);
        check("rst_flags", 64'({busy, done, taken, illegal}), 64'd0);
        check("rst_counts", 64'({taken_count, not_taken_count}), 64'd0);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;

        run_branch(32'hB400_0085, 5'b10000, 1'b0);   // CBZ X5, zero -> taken, constant 4
        run_branch(32'hB500_0085, 5'b10000, 1'b0);   // CBNZ X5, zero -> not taken
        run_branch(32'h3400_0085, 5'b10000, 1'b0);   // CBZ W5 via AND mask
        run_branch(32'h54FF_FFCC, 5'b01010, 1'b0);   // B.GT -2, N=V=1 Z=0 -> taken
        run_branch(32'h54FF_FFCC, 5'b00001, 1'b0);   // B.GT, Z=1 -> not taken
        run_illegal(32'h8B02_0020);                  // ADD

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                do ri = $urandom; while (kind_of(ri) != 3);
                run_illegal(ri);
            end else begin
                run_branch(rand_branch(), 5'($urandom), ($urandom_range(0, 15) == 0));
            end
        end

        for (int n = 0; n < CMAX + 3; n++) run_branch(32'hB400_0085, 5'b10000, 1'b0);
        check("sat_taken", 64'(taken_count), 64'(CMAX));
        run_branch(32'h5400_000E, 5'($urandom), 1'b1); // B.AL while saturated, clear wins

        instruction = 32'hB400_0085;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_cw", 64'(controlword), 64'd0);
        check("abort_flags", 64'({busy, done, taken, illegal}), 64'd0);
        check("abort_const", constant, 64'd0);
        model_taken = 0;
        model_not_taken = 0;
        @(negedge clock); reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clock); #1;
            check("abort_no_done", 64'({done, busy}), 64'd0);
        end
        check("abort_counts", 64'({taken_count, not_taken_count}), 64'd0);
        run_branch(32'h5400_0001, 5'b00000, 1'b0);    // B.NE with Z=0 -> taken

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
